// File: rtl/oc_dummy_seq.sv
// Repeatability sequencer for the dummy datapath: runs the dummy block N times and
// checks every run's folded lane signature against run 0. Timer gated by OC_DUMMY_SEQ_TIMEOUT_EN.
module oc_dummy_seq #(
  parameter int DatapathCount = 1,
  parameter int SettleCycles  = 16,
  parameter int GapCycles     = 8,
  parameter int TimeoutWidth  = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [15:0]                  runCount,
  input  logic [31:0]                  testChunks,
  input  logic [TimeoutWidth-1:0]      timeoutCycles,
  output logic                         dummyGo,
  output logic [31:0]                  dummyTestChunks,
  input  logic                         dummyDone,
  input  logic [DatapathCount*32-1:0]  dummySum,
  output logic                         busy,
  output logic                         pass,
  output logic                         fail,
  output logic                         timedOut,
  output logic                         aborted,
  output logic [15:0]                  runsDone,
  output logic [15:0]                  mismatchRun,
  output logic [31:0]                  signature
);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StSettle,
    StCapture,
    StGap,
    StDone
  } stateT;

  localparam int SettleW = $clog2(SettleCycles + 1);
  localparam int GapW    = $clog2(GapCycles + 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SettleCycles - 1);
  localparam logic [GapW-1:0]    GapLast    = GapW'(GapCycles - 1);

  stateT              state;
  logic [15:0]        runTarget;
  logic [SettleW-1:0] settleCnt;
  logic [GapW-1:0]    gapCnt;
  logic [31:0]        captureSig;
  logic [15:0]        runsDoneInc;

  function automatic logic [31:0] rotl32(input logic [31:0] value, input int amount);
    logic [63:0] doubled;
    doubled = {value, value} << amount;
    return doubled[63:32];
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    captureSig = '0;
    for (int i = 0; i < DatapathCount; i++) begin
      captureSig = captureSig ^ rotl32(dummySum[32*i +: 32], i % 32);
    end
  end

  assign runsDoneInc = (runsDone == 16'hFFFF) ? runsDone : runsDone + 16'd1;

`ifdef OC_DUMMY_SEQ_TIMEOUT_EN
  logic [TimeoutWidth-1:0] timer;
  logic                    timeoutHit;

  // The edge that would make the count equal the limit is the one that fires.
  assign timeoutHit = (timeoutCycles != '0) && ((timer + TimeoutWidth'(1)) == timeoutCycles);
`else
  logic unusedTimeout;

  assign unusedTimeout = ^timeoutCycles;
  assign timedOut      = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= StIdle;
      dummyGo         <= 1'b0;
      dummyTestChunks <= '0;
      busy            <= 1'b0;
      pass            <= 1'b0;
      fail            <= 1'b0;
      aborted         <= 1'b0;
      runsDone        <= '0;
      mismatchRun     <= '0;
      signature       <= '0;
      runTarget       <= '0;
      settleCnt       <= '0;
      gapCnt          <= '0;
`ifdef OC_DUMMY_SEQ_TIMEOUT_EN
      timer           <= '0;
      timedOut        <= 1'b0;
`endif
    end else if (busy && abort) begin
      state   <= StDone;
      dummyGo <= 1'b0;
      busy    <= 1'b0;
      aborted <= 1'b1;
      fail    <= 1'b1;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start && !dummyDone) begin
            state           <= StRun;
            dummyGo         <= 1'b1;
            busy            <= 1'b1;
            pass            <= 1'b0;
            fail            <= 1'b0;
            aborted         <= 1'b0;
            runsDone        <= '0;
            mismatchRun     <= '0;
            signature       <= '0;
            dummyTestChunks <= testChunks;
            runTarget       <= (runCount == 16'd0) ? 16'd1 : runCount;
`ifdef OC_DUMMY_SEQ_TIMEOUT_EN
            timedOut        <= 1'b0;
            timer           <= '0;
`endif
          end
        end

        StRun: begin
          if (dummyDone) begin
            state     <= StSettle;
            settleCnt <= '0;
          end
`ifdef OC_DUMMY_SEQ_TIMEOUT_EN
          else if (timeoutHit) begin
            state    <= StDone;
            dummyGo  <= 1'b0;
            busy     <= 1'b0;
            timedOut <= 1'b1;
            fail     <= 1'b1;
          end else begin
            timer <= timer + TimeoutWidth'(1);
          end
`endif
        end

        // dummyGo stays high here so the dummy block keeps its sums stable.
        StSettle: begin
          if (settleCnt == SettleLast) begin
            state <= StCapture;
          end else begin
            settleCnt <= settleCnt + SettleW'(1);
          end
        end

        StCapture: begin
          dummyGo <= 1'b0;
          if (runsDone != 16'd0 && captureSig != signature) begin
            state       <= StDone;
            busy        <= 1'b0;
            fail        <= 1'b1;
            mismatchRun <= runsDone;
          end else begin
            if (runsDone == 16'd0) begin
              signature <= captureSig;
            end
            runsDone <= runsDoneInc;
            gapCnt   <= '0;
            state    <= StGap;
          end
        end

        StGap: begin
          if (gapCnt != GapLast) begin
            gapCnt <= gapCnt + GapW'(1);
          end else if (!dummyDone) begin
            if (runsDone == runTarget) begin
              state <= StDone;
              busy  <= 1'b0;
              pass  <= 1'b1;
            end else begin
              state   <= StRun;
              dummyGo <= 1'b1;
`ifdef OC_DUMMY_SEQ_TIMEOUT_EN
              timer   <= '0;
`endif
            end
          end
        end

        default: begin
          state   <= StIdle;
          dummyGo <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oc_dummy_seq.sv
// Directed bench for oc_dummy_seq with a small behavioural dummy block (3 lanes).
module tb_oc_dummy_seq;

  localparam int Lanes = 3;
  localparam logic [31:0] Lane0  = 32'h8000_0001;
  localparam logic [31:0] Lane1  = 32'h1234_5678;
  localparam logic [31:0] Lane2  = 32'hF000_000F;
  // Lane0 ^ rotl(Lane1,1) ^ rotl(Lane2,2) = 80000001 ^ 2468ACF0 ^ C000003F
  localparam logic [31:0] ExpSig = 32'h6468_ACCE;

  logic              clock;
  logic              reset;
  logic              start;
  logic              abort;
  logic [15:0]       runCount;
  logic [31:0]       testChunks;
  logic [31:0]       timeoutCycles;
  logic              dummyGo;
  logic [31:0]       dummyTestChunks;
  logic              dummyDone;
  logic [Lanes*32-1:0] dummySum;
  logic              busy;
  logic              pass;
  logic              fail;
  logic              timedOut;
  logic              aborted;
  logic [15:0]       runsDone;
  logic [15:0]       mismatchRun;
  logic [31:0]       signature;

  int checks   = 0;
  int failures = 0;

  // Dummy block model controls (written by tests, read by the model)
  bit hang      = 0;
  bit forceDone = 0;
  int corruptRun = -1;

  // Dummy block model state (written only by the model)
  bit goActive  = 0;
  bit modelDone = 0;
  int curRun    = 0;
  int nextRun   = 0;
  int modelCnt  = 0;
  int lowCnt    = 0;
  int minGap    = 1000;

  oc_dummy_seq #(
    .DatapathCount(Lanes),
    .SettleCycles (16),
    .GapCycles    (8),
    .TimeoutWidth (32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .runCount       (runCount),
    .testChunks     (testChunks),
    .timeoutCycles  (timeoutCycles),
    .dummyGo        (dummyGo),
    .dummyTestChunks(dummyTestChunks),
    .dummyDone      (dummyDone),
    .dummySum       (dummySum),
    .busy           (busy),
    .pass           (pass),
    .fail           (fail),
    .timedOut       (timedOut),
    .aborted        (aborted),
    .runsDone       (runsDone),
    .mismatchRun    (mismatchRun),
    .signature      (signature)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign dummyDone = modelDone | forceDone;
  assign dummySum  = {Lane2, Lane1, (curRun == corruptRun) ? (Lane0 ^ 32'h1) : Lane0};

  // Dummy block: raises done (testChunks + 2) cycles after go, holds it until go drops.
  always @(negedge clock) begin
    if (!busy) nextRun = 0;
    if (!dummyGo) begin
      goActive  = 0;
      modelDone = 0;
      if (busy) lowCnt = lowCnt + 1;
    end else if (!goActive) begin
      goActive = 1;
      modelCnt = 0;
      if (nextRun == 0) minGap = 1000;
      else if (lowCnt < minGap) minGap = lowCnt;
      lowCnt  = 0;
      curRun  = nextRun;
      nextRun = nextRun + 1;
    end else begin
      modelCnt = modelCnt + 1;
      if (!hang && modelCnt >= int'(dummyTestChunks) + 2) modelDone = 1;
    end
  end

  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic waitModel(input int run, input bit needDone, input int budget, input string name);
    int n = 0;
    while (!(goActive && curRun == run && (!needDone || modelDone)) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!(goActive && curRun == run && (!needDone || modelDone))) begin
      failures++;
      $display("FAIL %s: run %0d (done=%0d) not reached in %0d cycles", name, run, needDone, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (dummyGo !== 1'b0) begin failures++; $display("FAIL reset_go: got %b want 0", dummyGo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({pass, fail, timedOut, aborted} !== 4'b0) begin failures++; $display("FAIL reset_flags: got %b want 0000", {pass, fail, timedOut, aborted}); end
    checks++; if (runsDone !== 16'd0 || mismatchRun !== 16'd0) begin failures++; $display("FAIL reset_counts: got %h/%h want 0/0", runsDone, mismatchRun); end
    checks++; if (signature !== 32'd0 || dummyTestChunks !== 32'd0) begin failures++; $display("FAIL reset_words: got %h/%h want 0/0", signature, dummyTestChunks); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_pass();
    runCount = 16'd3; testChunks = 32'd2; timeoutCycles = 32'd0; corruptRun = -1; hang = 0;
    pulseStart();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pass_busy_t1: got %b want 1", busy); end
    checks++; if (dummyGo !== 1'b1) begin failures++; $display("FAIL pass_go_t1: got %b want 1", dummyGo); end
    waitIdle(500, "pass_idle");
    checks++; if (pass !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL pass_flags: got pass=%b fail=%b want 1/0", pass, fail); end
    checks++; if (runsDone !== 16'd3) begin failures++; $display("FAIL pass_runs: got %0d want 3", runsDone); end
    checks++; if (signature !== ExpSig) begin failures++; $display("FAIL pass_sig: got %h want %h", signature, ExpSig); end
    checks++; if (dummyTestChunks !== 32'd2) begin failures++; $display("FAIL pass_chunks: got %0d want 2", dummyTestChunks); end
    checks++; if (minGap < 8) begin failures++; $display("FAIL pass_gap: got %0d want >=8", minGap); end
    checks++; if (dummyGo !== 1'b0) begin failures++; $display("FAIL pass_go_done: got %b want 0", dummyGo); end
  endtask

  task automatic test_mismatch();
    runCount = 16'd4; testChunks = 32'd3; corruptRun = 2;
    pulseStart();
    waitIdle(800, "mis_idle");
    checks++; if (fail !== 1'b1 || pass !== 1'b0) begin failures++; $display("FAIL mis_flags: got pass=%b fail=%b want 0/1", pass, fail); end
    checks++; if (mismatchRun !== 16'd2) begin failures++; $display("FAIL mis_run: got %0d want 2", mismatchRun); end
    checks++; if (runsDone !== 16'd2) begin failures++; $display("FAIL mis_runs: got %0d want 2", runsDone); end
    checks++; if (dummyGo !== 1'b0) begin failures++; $display("FAIL mis_go: got %b want 0", dummyGo); end
    checks++; if (signature !== ExpSig) begin failures++; $display("FAIL mis_sig: got %h want %h", signature, ExpSig); end
    corruptRun = -1;
  endtask

  task automatic test_timeout();
    runCount = 16'd2; testChunks = 32'd2; timeoutCycles = 32'd100; hang = 1;
    pulseStart();
`ifdef OC_DUMMY_SEQ_TIMEOUT_EN
    repeat (99) @(posedge clock);
    @(negedge clock);
    checks++; if (timedOut !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_early: got timedOut=%b busy=%b want 0/1", timedOut, busy); end
    @(posedge clock);
    @(negedge clock);
    checks++; if (timedOut !== 1'b1 || fail !== 1'b1) begin failures++; $display("FAIL to_fire: got timedOut=%b fail=%b want 1/1", timedOut, fail); end
    checks++; if (busy !== 1'b0 || dummyGo !== 1'b0) begin failures++; $display("FAIL to_stop: got busy=%b go=%b want 0/0", busy, dummyGo); end
`else
    repeat (10000) @(posedge clock);
    @(negedge clock);
    checks++; if (busy !== 1'b1 || dummyGo !== 1'b1) begin failures++; $display("FAIL to_wait: got busy=%b go=%b want 1/1", busy, dummyGo); end
    checks++; if (timedOut !== 1'b0) begin failures++; $display("FAIL to_tied: got %b want 0", timedOut); end
    abort = 1'b1;
    @(posedge clock);
    @(negedge clock);
    abort = 1'b0;
    checks++; if (aborted !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL to_abort: got aborted=%b busy=%b want 1/0", aborted, busy); end
`endif
    hang = 0;
    timeoutCycles = 32'd0;
  endtask

  task automatic test_abort();
    runCount = 16'd3; testChunks = 32'd5;
    pulseStart();
    waitModel(1, 0, 500, "ab_run1");
    runCount = 16'd9;
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    checks++; if (busy !== 1'b1 || runsDone !== 16'd1) begin failures++; $display("FAIL ab_start_busy: got busy=%b runs=%0d want 1/1", busy, runsDone); end
    checks++; if (signature !== ExpSig) begin failures++; $display("FAIL ab_start_sig: got %h want %h", signature, ExpSig); end
    waitModel(1, 1, 500, "ab_done1");
    @(posedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    @(negedge clock);
    abort = 1'b0;
    checks++; if (aborted !== 1'b1 || fail !== 1'b1 || pass !== 1'b0) begin failures++; $display("FAIL ab_flags: got ab=%b fail=%b pass=%b want 1/1/0", aborted, fail, pass); end
    checks++; if (dummyGo !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ab_stop: got go=%b busy=%b want 0/0", dummyGo, busy); end
    checks++; if (runsDone !== 16'd1) begin failures++; $display("FAIL ab_runs: got %0d want 1", runsDone); end
  endtask

  task automatic test_runcount_zero();
    runCount = 16'd0; testChunks = 32'd1;
    pulseStart();
    waitIdle(300, "rc0_idle");
    checks++; if (pass !== 1'b1 || runsDone !== 16'd1) begin failures++; $display("FAIL rc0_result: got pass=%b runs=%0d want 1/1", pass, runsDone); end
    checks++; if (signature !== ExpSig) begin failures++; $display("FAIL rc0_sig: got %h want %h", signature, ExpSig); end
    forceDone = 1;
    runCount = 16'd5;
    pulseStart();
    @(negedge clock);
    checks++; if (busy !== 1'b0 || dummyGo !== 1'b0) begin failures++; $display("FAIL donehi_idle: got busy=%b go=%b want 0/0", busy, dummyGo); end
    checks++; if (pass !== 1'b1 || runsDone !== 16'd1) begin failures++; $display("FAIL donehi_held: got pass=%b runs=%0d want 1/1", pass, runsDone); end
    forceDone = 0;
  endtask

  task automatic test_reset_midrun();
    runCount = 16'd2; testChunks = 32'd3;
    pulseStart();
    waitModel(1, 0, 500, "rst_run1");
    #2 reset = 1'b0;
    #1;
    checks++; if (dummyGo !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_async: got go=%b busy=%b want 0/0", dummyGo, busy); end
    checks++; if ({pass, fail, timedOut, aborted} !== 4'b0) begin failures++; $display("FAIL rst_flags: got %b want 0000", {pass, fail, timedOut, aborted}); end
    checks++; if (runsDone !== 16'd0 || signature !== 32'd0) begin failures++; $display("FAIL rst_regs: got runs=%0d sig=%h want 0/0", runsDone, signature); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    pulseStart();
    waitIdle(500, "rst_again");
    checks++; if (pass !== 1'b1 || runsDone !== 16'd2) begin failures++; $display("FAIL rst_rerun: got pass=%b runs=%0d want 1/2", pass, runsDone); end
    checks++; if (signature !== ExpSig) begin failures++; $display("FAIL rst_sig: got %h want %h", signature, ExpSig); end
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    runCount      = 16'd0;
    testChunks    = 32'd0;
    timeoutCycles = 32'd0;
    test_reset();
    test_pass();
    test_mismatch();
    test_timeout();
    test_abort();
    test_runcount_zero();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
